// File: rtl/csr_issue_unit.sv
// CSR issue stage: in-order instruction queue with serialised dispatch to the CSR execute unit.
// Operands are resolved at the head (immediate, bypass or GRF) when the op is dispatched.
module csr_issue_unit #(
  parameter int INSTR_W = 113,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int DEP_W   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_enq_valid,
  output logic                          o_enq_ready,
  input  logic [INSTR_W-1:0]            i_enq_instr,
  input  logic                          i_enq_use_imm,
  input  logic [DATA_W-1:0]             i_enq_imm,
  input  logic [DEP_W-1:0]              i_enq_dep_l,
  input  logic [DEP_W-1:0]              i_enq_dep_r,
  output logic [INSTR_W-1:0]            o_head_instr,
  input  logic [DATA_W-1:0]             i_grf_l,
  input  logic [DATA_W-1:0]             i_grf_r,
  input  logic                          i_byp_valid,
  input  logic [DATA_W-1:0]             i_byp_l,
  input  logic [DATA_W-1:0]             i_byp_r,
  output logic                          o_exe_valid,
  input  logic                          i_exe_ready,
  output logic [INSTR_W+2*DATA_W-1:0]   o_exe_payload,
  input  logic                          i_wb_done,
  input  logic                          i_flush,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic                          o_empty,
  output logic                          o_busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int PAY_W = INSTR_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WB = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               useImm;
    logic [DATA_W-1:0]  imm;
    logic [DEP_W-1:0]   depL;
    logic [DEP_W-1:0]   depR;
  } entry_t;

  state_t            state_r;
  state_t            stateNxt_s;
  entry_t            mem_r [DEPTH];
  entry_t            head_s;
  entry_t            enqEntry_s;
  logic [PW-1:0]     wrPtr_r;
  logic [PW-1:0]     rdPtr_r;
  logic              full_s;
  logic              empty_s;
  logic              enqFire_s;
  logic              pop_s;
  logic              canDisp_s;
  logic              readyL_s;
  logic              readyR_s;
  logic [DATA_W-1:0] opL_s;
  logic [DATA_W-1:0] opR_s;
  logic [DEP_W-1:0]  bypTag_s;
  logic              exeValid_r;
  logic [PAY_W-1:0]  payload_r;

  // Full when the wrap bits differ but the index bits match.
  assign full_s     = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
  assign empty_s    = (wrPtr_r == rdPtr_r);
  assign enqFire_s  = i_enq_valid && !full_s && !i_flush;
  assign head_s     = mem_r[rdPtr_r[AW-1:0]];
  assign bypTag_s   = {DEP_W{1'b1}};
  assign enqEntry_s = '{instr: i_enq_instr, useImm: i_enq_use_imm, imm: i_enq_imm,
                        depL: i_enq_dep_l, depR: i_enq_dep_r};

  // Queue storage write port; data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rstn && enqFire_s) begin
      mem_r[wrPtr_r[AW-1:0]] <= enqEntry_s;
    end
  end

  // Head operand selection and readiness.
  always_comb begin
    opL_s    = '0;
    opR_s    = '0;
    readyL_s = 1'b0;
    readyR_s = 1'b0;
    if (head_s.useImm) begin
      opL_s    = head_s.imm;
      readyL_s = 1'b1;
    end else if (head_s.depL == bypTag_s) begin
      opL_s    = i_byp_l;
      readyL_s = i_byp_valid;
    end else begin
      opL_s    = i_grf_l;
      readyL_s = 1'b1;
    end
    if (head_s.depR == bypTag_s) begin
      opR_s    = i_byp_r;
      readyR_s = i_byp_valid;
    end else begin
      opR_s    = i_grf_r;
      readyR_s = 1'b1;
    end
  end

  assign canDisp_s = !empty_s && readyL_s && readyR_s && !i_flush;

  // Dispatch FSM next-state and pop decision.
  always_comb begin
    stateNxt_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (canDisp_s) begin
          pop_s      = 1'b1;
          stateNxt_s = ISSUE;
        end else begin
          stateNxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (i_exe_ready) begin
          stateNxt_s = WAIT_WB;
        end else begin
          stateNxt_s = ISSUE;
        end
      end
      WAIT_WB: begin
        if (i_wb_done && canDisp_s) begin
          pop_s      = 1'b1;
          stateNxt_s = ISSUE;
        end else if (i_wb_done) begin
          stateNxt_s = IDLE;
        end else begin
          stateNxt_s = WAIT_WB;
        end
      end
      default: begin
        stateNxt_s = IDLE;
      end
    endcase
  end

  // FSM state register; flush returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else if (i_flush) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNxt_s;
    end
  end

  // Queue pointers with an extra wrap bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
    end else if (i_flush) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
    end else begin
      wrPtr_r <= wrPtr_r + PW'(enqFire_s);
      rdPtr_r <= rdPtr_r + PW'(pop_s);
    end
  end

  // Execute-side handshake registers; payload stays stable while valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exeValid_r <= 1'b0;
      payload_r  <= {PAY_W{1'b0}};
    end else if (i_flush) begin
      exeValid_r <= 1'b0;
      payload_r  <= {PAY_W{1'b0}};
    end else if (pop_s) begin
      exeValid_r <= 1'b1;
      payload_r  <= {head_s.instr, opL_s, opR_s};
    end else if (state_r == ISSUE && i_exe_ready) begin
      exeValid_r <= 1'b0;
    end else begin
      exeValid_r <= exeValid_r;
    end
  end

  assign o_enq_ready   = !full_s;
  assign o_head_instr  = empty_s ? {INSTR_W{1'b0}} : head_s.instr;
  assign o_exe_valid   = exeValid_r;
  assign o_exe_payload = payload_r;
  assign o_count       = wrPtr_r - rdPtr_r;
  assign o_empty       = empty_s;
  assign o_busy        = (state_r != IDLE);

endmodule

// File: tb/tb_csr_issue_unit.sv
// Directed plus randomized bench for csr_issue_unit, checked every cycle against a
// queue-based reference model of the issue stage.
module tb_csr_issue_unit;
  localparam int INSTR_W = 113;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int DEP_W   = 4;
  localparam int PAY_W   = INSTR_W + 2 * DATA_W;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rstn;
  logic               i_enq_valid;
  logic               o_enq_ready;
  logic [INSTR_W-1:0] i_enq_instr;
  logic               i_enq_use_imm;
  logic [DATA_W-1:0]  i_enq_imm;
  logic [DEP_W-1:0]   i_enq_dep_l;
  logic [DEP_W-1:0]   i_enq_dep_r;
  logic [INSTR_W-1:0] o_head_instr;
  logic [DATA_W-1:0]  i_grf_l;
  logic [DATA_W-1:0]  i_grf_r;
  logic               i_byp_valid;
  logic [DATA_W-1:0]  i_byp_l;
  logic [DATA_W-1:0]  i_byp_r;
  logic               o_exe_valid;
  logic               i_exe_ready;
  logic [PAY_W-1:0]   o_exe_payload;
  logic               i_wb_done;
  logic               i_flush;
  logic [CW-1:0]      o_count;
  logic               o_empty;
  logic               o_busy;

  always #5 clk = ~clk;

  csr_issue_unit #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DEP_W(DEP_W)) dut (
    .clk(clk), .rstn(rstn), .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .i_enq_instr(i_enq_instr), .i_enq_use_imm(i_enq_use_imm), .i_enq_imm(i_enq_imm),
    .i_enq_dep_l(i_enq_dep_l), .i_enq_dep_r(i_enq_dep_r), .o_head_instr(o_head_instr),
    .i_grf_l(i_grf_l), .i_grf_r(i_grf_r), .i_byp_valid(i_byp_valid), .i_byp_l(i_byp_l),
    .i_byp_r(i_byp_r), .o_exe_valid(o_exe_valid), .i_exe_ready(i_exe_ready),
    .o_exe_payload(o_exe_payload), .i_wb_done(i_wb_done), .i_flush(i_flush),
    .o_count(o_count), .o_empty(o_empty), .o_busy(o_busy)
  );

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               useImm;
    logic [DATA_W-1:0]  imm;
    logic [DEP_W-1:0]   depL;
    logic [DEP_W-1:0]   depR;
  } op_t;

  // Reference model: pending ops in order, one op offered to execute, one awaiting writeback.
  op_t              mq[$];
  bit               mValid;
  bit               mPend;
  logic [PAY_W-1:0] mPay;
  int               total = 0;
  int               bad   = 0;
  logic [PAY_W-1:0] expSingle;

  task automatic chk(input string tag, input logic [PAY_W-1:0] obs, input logic [PAY_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    op_t              e;
    bit               accept;
    bit               canGo;
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    e = '0;
    l = '0;
    r = '0;
    if (!rstn || i_flush) begin
      mq.delete();
      mValid = 1'b0;
      mPend  = 1'b0;
      if (!rstn) mPay = '0;
    end else begin
      accept = i_enq_valid && (mq.size() < DEPTH);
      canGo  = 1'b0;
      if (mq.size() > 0) begin
        e     = mq[0];
        l     = e.useImm ? e.imm : ((e.depL == 4'hF) ? i_byp_l : i_grf_l);
        r     = (e.depR == 4'hF) ? i_byp_r : i_grf_r;
        canGo = i_byp_valid || ((e.useImm || e.depL != 4'hF) && e.depR != 4'hF);
      end
      if (mValid) begin
        if (i_exe_ready) begin
          mValid = 1'b0;
          mPend  = 1'b1;
        end
      end else if (canGo && (!mPend || i_wb_done)) begin
        mPay = {e.instr, l, r};
        void'(mq.pop_front());
        mValid = 1'b1;
        mPend  = 1'b0;
      end else if (i_wb_done) begin
        mPend = 1'b0;
      end
      if (accept) mq.push_back('{i_enq_instr, i_enq_use_imm, i_enq_imm, i_enq_dep_l, i_enq_dep_r});
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    chk("valid", o_exe_valid, mValid);
    if (mValid) chk("payload", o_exe_payload, mPay);
    chk("count", o_count, mq.size());
    chk("empty", o_empty, mq.size() == 0);
    chk("enq_ready", o_enq_ready, mq.size() < DEPTH);
    chk("busy", o_busy, mValid || mPend);
    if (mq.size() > 0) chk("head", o_head_instr, mq[0].instr);
  endtask

  function automatic logic [INSTR_W-1:0] rndInstr();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[INSTR_W-1:0];
  endfunction

  function automatic logic [DEP_W-1:0] rndTag();
    return ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(14));
  endfunction

  task automatic quiet();
    i_enq_valid = 1'b0;
    i_exe_ready = 1'b0;
    i_wb_done   = 1'b0;
    i_flush     = 1'b0;
    i_byp_valid = 1'b0;
  endtask

  task automatic setEnq(input logic [INSTR_W-1:0] ins, input logic ui, input logic [DATA_W-1:0] im,
                        input logic [DEP_W-1:0] dl, input logic [DEP_W-1:0] dr);
    i_enq_valid   = 1'b1;
    i_enq_instr   = ins;
    i_enq_use_imm = ui;
    i_enq_imm     = im;
    i_enq_dep_l   = dl;
    i_enq_dep_r   = dr;
  endtask

  task automatic rndEnq();
    setEnq(rndInstr(), 1'($urandom_range(1)), $urandom(), rndTag(), rndTag());
  endtask

  task automatic rndAll();
    i_enq_valid = ($urandom_range(9) < 6);
    i_enq_instr = rndInstr();
    i_enq_use_imm = 1'($urandom_range(1));
    i_enq_imm   = $urandom();
    i_enq_dep_l = rndTag();
    i_enq_dep_r = rndTag();
    i_grf_l     = $urandom();
    i_grf_r     = $urandom();
    i_byp_l     = $urandom();
    i_byp_r     = $urandom();
    i_byp_valid = ($urandom_range(9) < 7);
    i_exe_ready = ($urandom_range(9) < 6);
    i_wb_done   = ($urandom_range(9) < 3);
    i_flush     = ($urandom_range(49) == 0);
  endtask

  initial begin
    mValid = 1'b0;
    mPend  = 1'b0;
    mPay   = '0;
    rstn   = 1'b0;
    rndAll();

    // Reset with random inputs for two cycles.
    tick();
    rndAll();
    tick();
    chk("rst_payload", o_exe_payload, '0);
    chk("rst_ready", o_enq_ready, 1'b1);

    // Single op: immediate left, GRF right.
    rstn = 1'b1;
    quiet();
    i_grf_l = $urandom();
    i_grf_r = 32'h77;
    setEnq(113'h1A, 1'b1, 32'h5, 4'h0, 4'h0);
    tick();
    i_enq_valid = 1'b0;
    chk("single_t1", o_exe_valid, 1'b0);
    tick();
    expSingle = {113'h1A, 32'h5, 32'h77};
    chk("single_t2_valid", o_exe_valid, 1'b1);
    chk("single_payload", o_exe_payload, expSingle);
    i_exe_ready = 1'b1;
    tick();
    i_exe_ready = 1'b0;
    tick();
    chk("single_waitwb", o_busy, 1'b1);
    i_wb_done = 1'b1;
    tick();
    i_wb_done = 1'b0;
    chk("single_idle", o_busy, 1'b0);

    // Serialisation: three ops, next dispatches in the writeback cycle.
    i_exe_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setEnq(rndInstr(), 1'b1, $urandom(), 4'h0, 4'h0);
      tick();
    end
    i_enq_valid = 1'b0;
    repeat (3) tick();
    chk("serial_hold", o_exe_valid, 1'b0);
    chk("serial_count", o_count, 5'd2);
    i_wb_done = 1'b1;
    tick();
    chk("serial_b2b", o_exe_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      i_wb_done = i[0];
      tick();
    end
    i_wb_done = 1'b1;
    tick();
    i_wb_done = 1'b0;
    i_exe_ready = 1'b0;

    // Fill to DEPTH behind a bypass-stalled head.
    setEnq(rndInstr(), 1'b0, 32'h0, 4'hF, 4'h0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      rndEnq();
      tick();
    end
    chk("full_count", o_count, 5'd16);
    chk("full_ready", o_enq_ready, 1'b0);
    rndEnq();
    tick();
    i_enq_valid = 1'b0;
    repeat (4) tick();
    chk("stall_novalid", o_exe_valid, 1'b0);
    i_byp_valid = 1'b1;
    i_byp_l     = 32'hDEAD;
    tick();
    chk("byp_opl", o_exe_payload[2*DATA_W-1:DATA_W], 32'hDEAD);
    chk("full_release", o_enq_ready, 1'b1);

    // Wrap: dispatch/writeback with concurrent enqueues.
    i_exe_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rndEnq();
      i_byp_l   = $urandom();
      i_byp_r   = $urandom();
      i_grf_l   = $urandom();
      i_grf_r   = $urandom();
      i_wb_done = i[0];
      tick();
    end

    // Flush while ISSUE with four queued plus a same-cycle enqueue.
    quiet();
    i_flush = 1'b1;
    tick();
    i_flush     = 1'b0;
    i_byp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rndEnq();
      tick();
    end
    chk("pre_flush_count", o_count, 5'd4);
    rndEnq();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_enq_valid = 1'b0;
    chk("flush_valid", o_exe_valid, 1'b0);
    chk("flush_count", o_count, 5'd0);
    chk("flush_idle", o_busy, 1'b0);

    // Reset mid-operation, then a stray writeback.
    rndEnq();
    i_exe_ready = 1'b1;
    tick();
    tick();
    i_enq_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    i_wb_done = 1'b1;
    tick();
    i_wb_done = 1'b0;
    chk("rst_mid_busy", o_busy, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rndAll();
      rstn = ($urandom_range(199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
